// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART boot loader: bytes -> LE words -> instruction memory, holds core in reset until END_WORD
// Optional idle timeout auto-finish enabled by PROG_TIMEOUT_EN.
module uart_prog_loader #(
   parameter int unsigned ADDR_W      = 14,
   parameter logic [31:0] END_WORD    = 32'h0000_0FFF,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx_i,
   input  logic [15:0]       clk_per_bit_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              core_rst_o,
   output logic              prog_done_o,
   output logic              frame_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t            state_q, state_d;
   logic [1:0]        rx_sync_q;
   logic [15:0]       cpb_q, cpb_d;
   logic [15:0]       baud_q, baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [23:0]       word_q, word_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              ferr_q, ferr_d;
   logic              rx_s;
   logic              byte_valid;
   logic [15:0]       cpb_in;
   logic [31:0]       full_word;
`ifdef PROG_TIMEOUT_EN
   logic              got_q, got_d;
   logic [31:0]       idle_q, idle_d;
`else
   logic              unused_timeout;
   assign unused_timeout = |TIMEOUT_CYC;
`endif

   assign rx_s      = rx_sync_q[1];
   assign cpb_in    = (clk_per_bit_i < 16'd2) ? 16'd2 : clk_per_bit_i;
   assign full_word = {shift_q, word_q};

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rx_sync_q  <= 2'b11;
         cpb_q      <= 16'd2;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         ferr_q     <= 1'b0;
`ifdef PROG_TIMEOUT_EN
         got_q      <= 1'b0;
         idle_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rx_sync_q  <= {rx_sync_q[0], rx_i};
         cpb_q      <= cpb_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         ferr_q     <= ferr_d;
`ifdef PROG_TIMEOUT_EN
         got_q      <= got_d;
         idle_q     <= idle_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cpb_d      = cpb_q;
      baud_d     = baud_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      done_d     = done_q;
      ferr_d     = ferr_q;
      byte_valid = 1'b0;

      if (we_q) addr_d = addr_q + ADDR_W'(1);

      // Once loading is finished the receiver is parked so every output stays frozen.
      if (!done_q) begin
         case (state_q)
            S_IDLE: if (!rx_s) begin
               state_d = S_START;
               cpb_d   = cpb_in;
               baud_d  = '0;
            end
            S_START: if (baud_q == (cpb_q >> 1) - 16'd1) begin
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = rx_s ? S_IDLE : S_DATA;
            end else baud_d = baud_q + 16'd1;
            S_DATA: if (baud_q == cpb_q - 16'd1) begin
               baud_d    = '0;
               shift_d   = {rx_s, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = S_STOP;
            end else baud_d = baud_q + 16'd1;
            S_STOP: if (baud_q == cpb_q - 16'd1) begin
               baud_d  = '0;
               state_d = S_IDLE;
               if (rx_s) byte_valid = 1'b1;
               else      ferr_d     = 1'b1;
            end else baud_d = baud_q + 16'd1;
            default: state_d = S_IDLE;
         endcase
      end

      if (byte_valid) begin
         byte_idx_d = byte_idx_q + 2'd1;
         case (byte_idx_q)
            2'd0: word_d[7:0]   = shift_q;
            2'd1: word_d[15:8]  = shift_q;
            2'd2: word_d[23:16] = shift_q;
            default: begin
               word_d = '0;
               if (full_word == END_WORD) done_d = 1'b1;
               else begin
                  we_d    = 1'b1;
                  wdata_d = full_word;
               end
            end
         endcase
      end

`ifdef PROG_TIMEOUT_EN
      got_d  = got_q | byte_valid;
      idle_d = idle_q;
      if (!done_q && state_q == S_IDLE) begin
         if (!rx_s) idle_d = '0;
         else if (got_q) begin
            // Flush a partial word first; finish on the following cycle.
            if (idle_q == TIMEOUT_CYC) begin
               if (byte_idx_q != 2'd0) begin
                  we_d       = 1'b1;
                  wdata_d    = {8'h00, word_q};
                  word_d     = '0;
                  byte_idx_d = '0;
               end else done_d = 1'b1;
            end else idle_d = idle_q + 32'd1;
         end
      end
`endif
   end

   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign core_rst_o  = ~done_q;
   assign prog_done_o = done_q;
   assign frame_err_o = ferr_q;

endmodule
